// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment codes,
// digit index type, guard state encoding and the buffered frame payload.
package seg7_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned DATA_W   = DIGITS * NIB_W;
  localparam int unsigned SEG_W    = 7;

  typedef logic [1:0] digit_idx_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A    = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B    = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C    = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D    = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F    = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;

  localparam logic [DIGITS-1:0] AN_OFF  = 4'b1111;

  // DARK: nothing shown since reset; GUARD: blanking after a digit change
  typedef enum logic [1:0] {
    ST_DARK  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] dp;
  } frame_t;

  function automatic logic [DIGITS-1:0] an_sel(input digit_idx_t idx);
    logic [DIGITS-1:0] one_hot;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment decoder; decimal mode shows a dash
// for values 10-15.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b1
) (
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = HEX_MODE ? SEG_A : SEG_DASH;
      4'hB: seg_c = HEX_MODE ? SEG_B : SEG_DASH;
      4'hC: seg_c = HEX_MODE ? SEG_C : SEG_DASH;
      4'hD: seg_c = HEX_MODE ? SEG_D : SEG_DASH;
      4'hE: seg_c = HEX_MODE ? SEG_E : SEG_DASH;
      4'hF: seg_c = HEX_MODE ? SEG_F : SEG_DASH;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: synchronises the external scan
// index, double-buffers display data per frame and blanks between digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 1,
  parameter bit          HEX_MODE     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        scan_sel,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DIGITS-1:0] dp_in,
  input  logic              blank_lz,
  output logic              busy,
  output logic              frame_done,
  output logic [DIGITS-1:0] an,
  output logic [SEG_W-1:0]  seg,
  output logic              dp
);

  localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned GW    = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_ONE  = GW'(1);

  digit_idx_t  sync_q [NSYNC];
  digit_idx_t  sel_s;
  digit_idx_t  sel_q;
  digit_idx_t  show_idx;
  logic        step;
  logic        wrap;

  scan_state_t state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  frame_t      pend_q, pend_d;
  frame_t      disp_q, disp_d;
  logic        busy_d;
  logic        frame_done_d;
  logic        show;
  logic [DIGITS-1:0] an_d;
  logic [SEG_W-1:0]  seg_d;
  logic              dp_d;

  logic [NIB_W-1:0] nibble;
  logic [SEG_W-1:0] dec_seg_c;
  logic             lz3, lz2, lz1;
  logic             blank;

  // Scan index synchroniser; sel_q trails the synchronised value by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYNC; i++) sync_q[i] <= '0;
      sel_q <= '0;
    end else begin
      sync_q[0] <= scan_sel;
      for (int i = 1; i < NSYNC; i++) sync_q[i] <= sync_q[i-1];
      sel_q <= sel_s;
    end
  end

  assign sel_s    = sync_q[NSYNC-1];
  assign step     = (sel_s != sel_q);
  assign wrap     = step && (sel_q == 2'd3) && (sel_s == 2'd0);
  // Outside a step sel_s equals sel_q, so this is the digit now selected
  assign show_idx = step ? sel_s : sel_q;

  // Frame buffering: pending captures loads, display takes pending at a wrap
  always_comb begin
    pend_d       = pend_q;
    disp_d       = disp_q;
    busy_d       = busy;
    frame_done_d = wrap;
    if (wrap) begin
      if (busy) disp_d = pend_q;
      busy_d = 1'b0;
    end
    if (load) begin
      pend_d.data = data_in;
      pend_d.dp   = dp_in;
      busy_d      = 1'b1;
    end
  end

  // Leading-zero blanking from the value about to be shown
  always_comb begin
    lz3   = (disp_d.data[15:12] == 4'h0);
    lz2   = lz3 && (disp_d.data[11:8] == 4'h0);
    lz1   = lz2 && (disp_d.data[7:4] == 4'h0);
    blank = 1'b0;
    case (show_idx)
      2'd3:    blank = blank_lz && lz3;
      2'd2:    blank = blank_lz && lz2;
      2'd1:    blank = blank_lz && lz1;
      default: blank = 1'b0;
    endcase
  end

  assign nibble = disp_d.data[{show_idx, 2'b00} +: NIB_W];

  seg7_decode #(
    .HEX_MODE (HEX_MODE)
  ) u_decode (
    .nibble (nibble),
    .seg_c  (dec_seg_c)
  );

  // Guard sequencing and output selection
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    show    = 1'b0;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;

    case (state_q)
      ST_DARK: begin
        show = 1'b0;
      end
      ST_GUARD: begin
        if (guard_q != GUARD_ONE) begin
          guard_d = guard_q - GUARD_ONE;
        end else begin
          guard_d = '0;
          state_d = ST_SHOW;
          show    = 1'b1;
        end
      end
      ST_SHOW: begin
        show = 1'b1;
      end
      default: begin
        state_d = ST_DARK;
      end
    endcase

    if (step) begin
      if (GUARD_CYCLES == 0) begin
        state_d = ST_SHOW;
        guard_d = '0;
        show    = 1'b1;
      end else begin
        state_d = ST_GUARD;
        guard_d = GUARD_LOAD;
        show    = 1'b0;
      end
    end

    if (show) begin
      an_d  = an_sel(show_idx);
      seg_d = blank ? SEG_OFF : dec_seg_c;
      dp_d  = ~disp_d.dp[show_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DARK;
      guard_q    <= '0;
      pend_q     <= '0;
      disp_q     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances (default, decimal mode,
// two-cycle guard) share stimulus; a vector table drives the scan sequence.
module tb_seg7_scan_driver;

  localparam logic [6:0] T0    = 7'h40;
  localparam logic [6:0] T1    = 7'h79;
  localparam logic [6:0] T2    = 7'h24;
  localparam logic [6:0] T3    = 7'h30;
  localparam logic [6:0] T5    = 7'h12;
  localparam logic [6:0] TA    = 7'h08;
  localparam logic [6:0] TF    = 7'h0E;
  localparam logic [6:0] TDASH = 7'h3F;
  localparam logic [6:0] TOFF  = 7'h7F;

  logic        clk;
  logic        rst_n;
  logic [1:0]  scan_sel;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic       d_busy, d_fd, d_dp;
  logic [3:0] d_an;
  logic [6:0] d_seg;
  logic       x_busy, x_fd, x_dp;
  logic [3:0] x_an;
  logic [6:0] x_seg;
  logic       g_busy, g_fd, g_dp;
  logic [3:0] g_an;
  logic [6:0] g_seg;

  int checks;
  int errors;

  typedef struct {
    bit         inst;
    logic [1:0] sel;
    bit         fd;
    bit         busy;
    logic [3:0] an;
    logic [6:0] seg;
    bit         dp;
  } vec_t;

  vec_t tbl [$];

  seg7_scan_driver #(.SYNC_STAGES(2), .GUARD_CYCLES(1), .HEX_MODE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .busy(d_busy), .frame_done(d_fd),
    .an(d_an), .seg(d_seg), .dp(d_dp));

  seg7_scan_driver #(.SYNC_STAGES(2), .GUARD_CYCLES(1), .HEX_MODE(1'b0)) u_dec (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .busy(x_busy), .frame_done(x_fd),
    .an(x_an), .seg(x_seg), .dp(x_dp));

  seg7_scan_driver #(.SYNC_STAGES(2), .GUARD_CYCLES(2), .HEX_MODE(1'b1)) u_g2 (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .busy(g_busy), .frame_done(g_fd),
    .an(g_an), .seg(g_seg), .dp(g_dp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_row(input bit inst, input logic [1:0] sel, input bit fd, input bit busy,
                         input logic [3:0] an, input logic [6:0] seg, input bit dp);
    vec_t v;
    v.inst = inst; v.sel = sel; v.fd = fd; v.busy = busy;
    v.an = an; v.seg = seg; v.dp = dp;
    tbl.push_back(v);
  endtask

  // One-cycle load strobe; busy must be set after the capturing edge
  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; data_in = d; dp_in = p;
    @(negedge clk);
    load = 1'b0;
    check($sformatf("load_busy_%0h", d), 32'(d_busy), 32'd1);
  endtask

  // Change scan_sel and watch 8 cycles: frame pulse, guard length, anode latency
  task automatic step_watch(input logic [1:0] nsel, input bit exp_fd, input int row);
    int fd_cnt, fd_idx, d_idx, d_off, g_idx, g_off;
    logic [3:0] one_hot;
    logic [3:0] want;
    fd_cnt = 0; fd_idx = 0; d_idx = 0; d_off = 0; g_idx = 0; g_off = 0;
    one_hot = 4'b0001 << nsel;
    want = ~one_hot;
    scan_sel = nsel;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (d_fd) begin
        fd_cnt++;
        if (fd_idx == 0) fd_idx = i;
      end
      if (i >= 3 && d_an == 4'hF) d_off++;
      if (i >= 3 && g_an == 4'hF) g_off++;
      if (d_idx == 0 && d_an == want) d_idx = i;
      if (g_idx == 0 && g_an == want) g_idx = i;
    end
    check($sformatf("row%0d_fd_count", row), 32'(fd_cnt), 32'(exp_fd));
    if (exp_fd) check($sformatf("row%0d_fd_cycle", row), 32'(fd_idx), 32'd3);
    check($sformatf("row%0d_g1_latency", row), 32'(d_idx), 32'd4);
    check($sformatf("row%0d_g1_guard", row), 32'(d_off), 32'd1);
    check($sformatf("row%0d_g2_latency", row), 32'(g_idx), 32'd5);
    check($sformatf("row%0d_g2_guard", row), 32'(g_off), 32'd2);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      step_watch(tbl[r].sel, tbl[r].fd, r);
      if (tbl[r].inst == 1'b0) begin
        check($sformatf("row%0d_busy", r), 32'(d_busy), 32'(tbl[r].busy));
        check($sformatf("row%0d_an", r),   32'(d_an),   32'(tbl[r].an));
        check($sformatf("row%0d_seg", r),  32'(d_seg),  32'(tbl[r].seg));
        check($sformatf("row%0d_dp", r),   32'(d_dp),   32'(tbl[r].dp));
      end else begin
        check($sformatf("row%0d_dec_busy", r), 32'(x_busy), 32'(tbl[r].busy));
        check($sformatf("row%0d_dec_an", r),   32'(x_an),   32'(tbl[r].an));
        check($sformatf("row%0d_dec_seg", r),  32'(x_seg),  32'(tbl[r].seg));
        check($sformatf("row%0d_dec_dp", r),   32'(x_dp),   32'(tbl[r].dp));
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; scan_sel = 2'd0; load = 1'b0; data_in = '0; dp_in = '0; blank_lz = 1'b0;

    // inst, sel, fd, busy, an, seg, dp
    add_row(0, 2'd1, 0, 0, 4'b1101, T0, 1);     // 0: first step after reset
    add_row(0, 2'd0, 0, 0, 4'b1110, T0, 1);     // 1: 1->0 is not a wrap
    add_row(0, 2'd1, 0, 1, 4'b1101, T0, 1);     // 2: 12AF pending
    add_row(0, 2'd2, 0, 1, 4'b1011, T0, 1);     // 3
    add_row(0, 2'd3, 0, 1, 4'b0111, T0, 1);     // 4
    add_row(0, 2'd0, 1, 0, 4'b1110, TF, 1);     // 5: commit 12AF
    add_row(0, 2'd1, 0, 0, 4'b1101, TA, 1);     // 6
    add_row(0, 2'd2, 0, 0, 4'b1011, T2, 0);     // 7: dp lit on digit 2
    add_row(0, 2'd3, 0, 0, 4'b0111, T1, 1);     // 8
    add_row(0, 2'd1, 0, 1, 4'b1101, TA, 1);     // 9: 3->1 jump, no commit
    add_row(0, 2'd3, 0, 1, 4'b0111, T1, 1);     // 10: 1->3 jump
    add_row(0, 2'd0, 1, 0, 4'b1110, T5, 1);     // 11: commit 5555
    add_row(0, 2'd1, 0, 1, 4'b1101, T5, 1);     // 12: 1111 then 2222 pending
    add_row(0, 2'd2, 0, 1, 4'b1011, T5, 1);     // 13
    add_row(0, 2'd3, 0, 1, 4'b0111, T5, 1);     // 14
    add_row(0, 2'd1, 0, 1, 4'b1101, T2, 1);     // 15: 3333 still pending
    add_row(0, 2'd2, 0, 1, 4'b1011, T2, 1);     // 16
    add_row(0, 2'd3, 0, 1, 4'b0111, T2, 1);     // 17
    add_row(0, 2'd0, 1, 0, 4'b1110, T3, 1);     // 18: commit 3333
    add_row(0, 2'd1, 0, 0, 4'b1101, T3, 1);     // 19
    add_row(0, 2'd2, 0, 1, 4'b1011, T3, 1);     // 20: 00C5 pending, blank_lz on
    add_row(0, 2'd3, 0, 1, 4'b0111, T3, 1);     // 21
    add_row(0, 2'd0, 1, 0, 4'b1110, T5, 1);     // 22: commit 00C5
    add_row(1, 2'd1, 0, 0, 4'b1101, TDASH, 1);  // 23: decimal C -> dash
    add_row(1, 2'd2, 0, 0, 4'b1011, TOFF, 0);   // 24: blanked, dp kept
    add_row(1, 2'd3, 0, 0, 4'b0111, TOFF, 1);   // 25: blanked
    add_row(1, 2'd0, 1, 0, 4'b1110, T5, 1);     // 26
    add_row(0, 2'd2, 0, 0, 4'b1011, TOFF, 0);   // 27: hex instance also blanks
    add_row(0, 2'd3, 0, 0, 4'b0111, T0, 1);     // 28: after reset, display 0
    add_row(0, 2'd0, 1, 0, 4'b1110, T0, 1);     // 29: pending lost at reset

    repeat (3) @(negedge clk);
    check("rst_an",   32'(d_an),   32'hF);
    check("rst_seg",  32'(d_seg),  32'h7F);
    check("rst_dp",   32'(d_dp),   32'd1);
    check("rst_busy", 32'(d_busy), 32'd0);
    check("rst_fd",   32'(d_fd),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_rows(0, 1);
    do_load(16'h12AF, 4'b0100);
    run_rows(2, 8);
    do_load(16'h5555, 4'b0000);
    run_rows(9, 11);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    run_rows(12, 14);

    // Load coincident with the commit edge (third edge after the change)
    scan_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; data_in = 16'h3333; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    check("coinc_fd",   32'(d_fd),   32'd1);
    check("coinc_busy", 32'(d_busy), 32'd1);
    @(negedge clk);
    check("coinc_fd_off", 32'(d_fd), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("coinc_an",  32'(d_an),  32'hE);
    check("coinc_seg", 32'(d_seg), 32'(T2));
    run_rows(15, 19);

    blank_lz = 1'b1;
    do_load(16'h00C5, 4'b0100);
    run_rows(20, 27);

    // Reset while digit 2 is lit and a load is pending
    do_load(16'h9999, 4'b1111);
    blank_lz = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_an",   32'(d_an),   32'hF);
    check("midrst_seg",  32'(d_seg),  32'h7F);
    check("midrst_dp",   32'(d_dp),   32'd1);
    check("midrst_busy", 32'(d_busy), 32'd0);
    check("midrst_fd",   32'(d_fd),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("postrst_an",   32'(d_an),   32'hB);
    check("postrst_seg",  32'(d_seg),  32'(T0));
    check("postrst_dp",   32'(d_dp),   32'd1);
    check("postrst_busy", 32'(d_busy), 32'd0);
    run_rows(28, 29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
